// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 (LSU) has priority, capped so port 1 (debug/loader) cannot starve.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req_valid/ready   per-port handshake, bit i = port i
//   req_we/addr/wdata per-port request fields, port i at slice i
//   rsp_valid         one-cycle response pulse per port
//   rsp_err/rdata     shared response payload, qualified by rsp_valid
//   mem_*             single-port synchronous memory interface
//   fault_count       saturating count of faulting requests
module dmem_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int MEM_SIZE   = 1024,
    parameter int MAX_CONSEC = 4,
    localparam int IDX_W     = $clog2(MEM_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic                    rsp_err,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [IDX_W-1:0]        mem_idx,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [31:0]             fault_count
);

    localparam int CW = $clog2(MAX_CONSEC + 1);

    logic [CW-1:0]         consec_q, consec_d;
    logic [31:0]           fcnt_q, fcnt_d;
    logic                  rvld_q, rvld_d;
    logic                  rport_q, rport_d;
    logic                  rerr_q, rerr_d;
    logic                  rload_q, rload_d;

    logic [1:0]            grant;
    logic                  accept;
    logic                  sel;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic                  fault;

    // Grants are suppressed while in reset so ready reads 0 then.
    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            if (req_valid[0] &&
                !(req_valid[1] && consec_q == CW'(MAX_CONSEC))) begin
                grant = 2'b01;
            end else if (req_valid[1]) begin
                grant = 2'b10;
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel       = grant[1];
    assign sel_addr  = sel ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                           : req_addr[0 +: ADDR_WIDTH];
    assign sel_we    = req_we[sel];

    assign fault = (sel_addr[2:0] != 3'd0) ||
                   ((sel_addr >> 3) >= ADDR_WIDTH'(MEM_SIZE));

    assign mem_en    = accept && !fault;
    assign mem_we    = mem_en && sel_we;
    assign mem_idx   = sel_addr[IDX_W+2:3];
    assign mem_wdata = sel ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                           : req_wdata[0 +: DATA_WIDTH];

    always_comb begin
        consec_d = consec_q;
        fcnt_d   = fcnt_q;
        rvld_d   = accept;
        rport_d  = sel;
        rerr_d   = fault;
        rload_d  = !sel_we;
        // The streak only counts p0 wins against a waiting p1.
        if (!req_valid[1] || grant[1]) begin
            consec_d = '0;
        end else if (grant[0]) begin
            consec_d = consec_q + 1'b1;
        end
        if (accept && fault && fcnt_q != 32'hFFFF_FFFF) begin
            fcnt_d = fcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            consec_q <= '0;
            fcnt_q   <= '0;
            rvld_q   <= 1'b0;
            rport_q  <= 1'b0;
            rerr_q   <= 1'b0;
            rload_q  <= 1'b0;
        end else begin
            consec_q <= consec_d;
            fcnt_q   <= fcnt_d;
            rvld_q   <= rvld_d;
            rport_q  <= rport_d;
            rerr_q   <= rerr_d;
            rload_q  <= rload_d;
        end
    end

    assign rsp_valid   = {rvld_q & rport_q, rvld_q & ~rport_q};
    assign rsp_err     = rvld_q & rerr_q;
    // Memory read data lands in the response cycle; only good loads pass it.
    assign rsp_rdata   = (rvld_q && !rerr_q && rload_q) ? mem_rdata : '0;
    assign fault_count = fcnt_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of the arbiter and memory.
module tb_dmem_port_arbiter;

    localparam int MAXC = 4;
    localparam int MEMW = 1024;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid, req_ready, req_we, rsp_valid;
    logic [127:0] req_addr, req_wdata;
    logic         rsp_err, mem_en, mem_we;
    logic [63:0]  rsp_rdata, mem_wdata, mem_rdata;
    logic [9:0]   mem_idx;
    logic [31:0]  fault_count;

    dmem_port_arbiter #(
        .DATA_WIDTH(64), .ADDR_WIDTH(64),
        .MEM_SIZE(MEMW), .MAX_CONSEC(MAXC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [MEMW];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_idx] <= mem_wdata;
            mem_rdata <= mem[mem_idx];
        end
    end

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [63:0] rmem [int];
    int          streak;
    int          fcnt;
    logic        p_v, p_port, p_err;
    logic [63:0] p_data;

    // Observations captured in the last step
    logic [1:0]  o_rv;
    logic        o_err;
    logic [63:0] o_rdata;
    logic [31:0] o_fc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rd(input logic [63:0] idx);
        return rmem.exists(int'(idx)) ? rmem[int'(idx)] : 64'd0;
    endfunction

    task automatic model_reset();
        streak = 0;
        fcnt   = 0;
        p_v    = 1'b0;
        p_port = 1'b0;
        p_err  = 1'b0;
        p_data = 64'd0;
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [63:0] a0, input logic [63:0] a1,
                        input logic [63:0] d0, input logic [63:0] d1,
                        output logic [1:0] g);
        logic eg0, eg1, p, flt, en;
        logic [63:0] a, d;
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        @(negedge clk);
        eg0 = v[0] && !(v[1] && streak == MAXC);
        eg1 = v[1] && !eg0;
        p   = eg1;
        a   = p ? a1 : a0;
        d   = p ? d1 : d0;
        flt = (a[2:0] != 3'd0) || ((a >> 3) >= 64'(MEMW));
        en  = (eg0 || eg1) && !flt;
        o_rv = rsp_valid; o_err = rsp_err;
        o_rdata = rsp_rdata; o_fc = fault_count;
        chk("ready", 64'(req_ready), 64'({eg1, eg0}));
        chk("mem_en", 64'(mem_en), 64'(en));
        if (en) begin
            chk("mem_we", 64'(mem_we), 64'(we[p]));
            chk("mem_idx", 64'(mem_idx), 64'(a >> 3));
            if (we[p]) chk("mem_wdata", mem_wdata, d);
        end
        chk("rsp_valid", 64'(rsp_valid),
            p_v ? (p_port ? 64'd2 : 64'd1) : 64'd0);
        chk("rsp_err", 64'(rsp_err), 64'(p_v && p_err));
        chk("rsp_rdata", rsp_rdata, p_v ? p_data : 64'd0);
        chk("fault_count", 64'(fault_count), 64'(fcnt));
        @(posedge clk);
        #1;
        p_v    = eg0 || eg1;
        p_port = p;
        p_err  = flt;
        p_data = (en && !we[p]) ? rd(a >> 3) : 64'd0;
        if (en && we[p]) rmem[int'(a >> 3)] = d;
        if (!v[1] || eg1) streak = 0;
        else if (eg0) streak = streak + 1;
        if ((eg0 || eg1) && flt) fcnt = fcnt + 1;
        g = {eg1, eg0};
    endtask

    function automatic logic [63:0] rnd_addr();
        int r;
        logic [63:0] idx;
        r   = $urandom_range(0, 9);
        idx = 64'($urandom_range(0, 15));
        if (r < 6) return idx << 3;
        if (r < 8) return (idx << 3) | 64'($urandom_range(1, 7));
        if (r < 9) return (64'(MEMW) + 64'($urandom_range(0, 4000))) << 3;
        return {$urandom, $urandom};
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rv"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_rdata"}, rsp_rdata, 64'd0);
        chk({tag, "_en"}, 64'(mem_en), 64'd0);
        chk({tag, "_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_fc"}, 64'(fault_count), 64'd0);
    endtask

    initial begin
        logic [1:0]  g;
        logic [1:0]  cv, cwe;
        logic [63:0] ca [2];
        logic [63:0] cd [2];

        for (int i = 0; i < MEMW; i++) mem[i] = 64'd0;
        mem_rdata = 64'd0;
        rst_n     = 1'b0;
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step(2'b00, 2'b00, 0, 0, 0, 0, g);
        chk("no_rsp_after_rst", 64'(o_rv), 64'd0);

        // p0 store 5 @0, load @0
        step(2'b01, 2'b01, 64'h0, 0, 64'd5, 0, g);
        step(2'b01, 2'b00, 64'h0, 0, 0, 0, g);
        chk("st_rsp_valid", 64'(o_rv), 64'd1);
        chk("st_rsp_err", 64'(o_err), 64'd0);
        step(2'b00, 2'b00, 0, 0, 0, 0, g);
        chk("ld_rdata", o_rdata, 64'd5);

        // Both continuously valid: p0 x4 then p1
        for (int k = 0; k < 10; k++) begin
            step(2'b11, 2'b00, 64'h0, 64'h8, 0, 0, g);
            chk("grant_seq", 64'(g), (k % 5 == 4) ? 64'd2 : 64'd1);
        end
        step(2'b00, 2'b00, 0, 0, 0, 0, g);

        // Faulting p1 loads
        step(2'b10, 2'b00, 0, 64'h4, 0, 0, g);
        step(2'b10, 2'b00, 0, 64'h2000, 0, 0, g);
        chk("flt1_err", 64'(o_err), 64'd1);
        chk("flt1_rdata", o_rdata, 64'd0);
        step(2'b00, 2'b00, 0, 0, 0, 0, g);
        chk("flt2_err", 64'(o_err), 64'd1);
        chk("flt2_rv", 64'(o_rv), 64'd2);
        chk("flt_count", 64'(o_fc), 64'd2);

        // Back-to-back p1 stores
        for (int k = 0; k < 4; k++) begin
            step(2'b10, 2'b10, 0, 64'(k * 8), 0, 64'd5, g);
            chk("b2b_grant", 64'(g), 64'd2);
            if (k > 0) chk("b2b_rv", 64'(o_rv), 64'd2);
        end
        step(2'b00, 2'b00, 0, 0, 0, 0, g);
        chk("b2b_rv_last", 64'(o_rv), 64'd2);
        for (int k = 0; k < 4; k++) chk("b2b_mem", mem[k], 64'd5);

        // Reset right after a load accept
        step(2'b01, 2'b00, 64'h8, 0, 0, 0, g);
        rst_n     = 1'b0;
        req_valid = 2'b01;
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(2'b00, 2'b00, 0, 0, 0, 0, g);
        chk("post_rst_rv", 64'(o_rv), 64'd0);
        step(2'b01, 2'b00, 64'h18, 0, 0, 0, g);
        step(2'b00, 2'b00, 0, 0, 0, 0, g);
        chk("post_rst_ld", o_rdata, 64'd5);

        // Random traffic, holding requests stable until granted
        cv = 2'b00;
        cwe = 2'b00;
        ca[0] = 0; ca[1] = 0; cd[0] = 0; cd[1] = 0;
        for (int n = 0; n < 400; n++) begin
            step(cv, cwe, ca[0], ca[1], cd[0], cd[1], g);
            for (int i = 0; i < 2; i++) begin
                if (!(cv[i] && !g[i])) begin
                    cv[i]  = ($urandom_range(0, 9) < 7);
                    cwe[i] = 1'($urandom_range(0, 1));
                    ca[i]  = rnd_addr();
                    cd[i]  = {$urandom, $urandom};
                end
            end
        end
        step(2'b00, 2'b00, 0, 0, 0, 0, g);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
